// File: rtl/sigan_pkg.sv
// Shared types and constants for the signature analyzer sequencer.
// Provides the state encoding, default widths, LFSR taps and the LFSR step function.
package sigan_pkg;

  localparam int SIG_W_DEF = 16;
  localparam int CNT_W_DEF = 20;

  localparam int TAP0 = 6;
  localparam int TAP1 = 8;
  localparam int TAP2 = 11;
  localparam int TAP3 = 15;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_RUN   = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  function automatic logic [SIG_W_DEF-1:0] lfsr_step(
    input logic [SIG_W_DEF-1:0] w,
    input logic                 d
  );
    logic fb;
    fb = d ^ w[TAP0] ^ w[TAP1] ^ w[TAP2] ^ w[TAP3];
    return {w[SIG_W_DEF-2:0], fb};
  endfunction

endpackage

// File: rtl/sigan_lfsr.sv
// 16-bit signature LFSR word generator.
// Ports: clock, reset, clear, shift_en, data_in -> word.
module sigan_lfsr
  import sigan_pkg::*;
#(
  parameter int SIG_W = SIG_W_DEF
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             clear,
  input  logic             shift_en,
  input  logic             data_in,
  output logic [SIG_W-1:0] word
);

  always_ff @(posedge clock) begin
    if (reset || clear) begin
      word <= '0;
    end else if (shift_en) begin
      word <= lfsr_step(word, data_in);
    end
  end

endmodule

// File: rtl/sigan_sequencer.sv
// Measurement sequencer: edge qualify, window FSM, LFSR drive, result handshake.
// Ports: clock, reset, start_in, stop_in, data_in, start_edge, stop_edge,
//   continuous, arm, abort, result_ready -> result_valid, signature,
//   window_len, timeout, unstable, busy.
// Option SIGAN_SEQ_QUAL_EN adds qual_in/qual_level clock qualification.
module sigan_sequencer
  import sigan_pkg::*;
#(
  parameter int SIG_W      = SIG_W_DEF,
  parameter int CNT_W      = CNT_W_DEF,
  parameter int MAX_WINDOW = (1 << CNT_W) - 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start_in,
  input  logic             stop_in,
  input  logic             data_in,
  input  logic             start_edge,
  input  logic             stop_edge,
  input  logic             continuous,
  input  logic             arm,
  input  logic             abort,
`ifdef SIGAN_SEQ_QUAL_EN
  input  logic             qual_in,
  input  logic             qual_level,
`endif
  output logic             result_valid,
  input  logic             result_ready,
  output logic [SIG_W-1:0] signature,
  output logic [CNT_W-1:0] window_len,
  output logic             timeout,
  output logic             unstable,
  output logic             busy
);

  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_WINDOW);

  logic qual;
`ifdef SIGAN_SEQ_QUAL_EN
  assign qual = (qual_in == qual_level);
`else
  assign qual = 1'b1;
`endif

  logic start_q;
  logic stop_q;
  logic primed;
  logic start_evt;
  logic stop_evt;

  // primed keeps the first post-reset sample from looking like an edge
  always_ff @(posedge clock) begin
    if (reset) begin
      start_q <= 1'b0;
      stop_q  <= 1'b0;
      primed  <= 1'b0;
    end else if (qual) begin
      start_q <= start_in;
      stop_q  <= stop_in;
      primed  <= 1'b1;
    end
  end

  assign start_evt = qual && primed && (start_q != start_in)
                     && (start_in == ~start_edge);
  assign stop_evt  = qual && primed && (stop_q != stop_in)
                     && (stop_in == ~stop_edge);

  state_t           state;
  state_t           state_nx;
  logic             lfsr_clr;
  logic             shift_en;
  logic             cnt_clr;
  logic             to_set;
  logic             latch;
  logic             accept;
  logic             prev_clr;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_inc;
  logic             win_to;
  logic [SIG_W-1:0] word;
  logic [SIG_W-1:0] prev_sig;
  logic             prev_valid;

  assign cnt_inc = cnt + 1'b1;

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    lfsr_clr = 1'b0;
    shift_en = 1'b0;
    cnt_clr  = 1'b0;
    to_set   = 1'b0;
    latch    = 1'b0;
    accept   = 1'b0;
    prev_clr = 1'b0;
    if (abort) begin
      state_nx = ST_IDLE;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (arm) begin
            state_nx = ST_ARMED;
            lfsr_clr = 1'b1;
            cnt_clr  = 1'b1;
            prev_clr = !continuous;
          end
        end
        ST_ARMED: begin
          if (start_evt) begin
            shift_en = 1'b1;
            state_nx = stop_evt ? ST_DONE : ST_RUN;
          end
        end
        ST_RUN: begin
          if (qual) begin
            shift_en = 1'b1;
            if (stop_evt) begin
              state_nx = ST_DONE;
            end else if (cnt_inc == MAX_CNT) begin
              state_nx = ST_DONE;
              to_set   = 1'b1;
            end
          end
        end
        ST_DONE: begin
          // first DONE cycle latches; later cycles wait for the host
          if (!result_valid) begin
            latch = 1'b1;
          end else if (result_ready) begin
            accept   = 1'b1;
            lfsr_clr = 1'b1;
            cnt_clr  = 1'b1;
            state_nx = continuous ? ST_ARMED : ST_IDLE;
          end
        end
      endcase
    end
  end

  sigan_lfsr #(
    .SIG_W (SIG_W)
  ) u_lfsr (
    .clock    (clock),
    .reset    (reset),
    .clear    (lfsr_clr),
    .shift_en (shift_en),
    .data_in  (data_in),
    .word     (word)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      cnt    <= '0;
      win_to <= 1'b0;
    end else begin
      if (cnt_clr) begin
        cnt <= '0;
      end else if (shift_en) begin
        cnt <= cnt_inc;
      end
      if (cnt_clr) begin
        win_to <= 1'b0;
      end else if (to_set) begin
        win_to <= 1'b1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      result_valid <= 1'b0;
      signature    <= '0;
      window_len   <= '0;
      timeout      <= 1'b0;
      unstable     <= 1'b0;
      prev_sig     <= '0;
      prev_valid   <= 1'b0;
    end else if (abort) begin
      result_valid <= 1'b0;
    end else begin
      if (latch) begin
        result_valid <= 1'b1;
        signature    <= word;
        window_len   <= cnt;
        timeout      <= win_to;
        unstable     <= prev_valid && (word != prev_sig);
      end else if (accept) begin
        result_valid <= 1'b0;
        prev_sig     <= signature;
        prev_valid   <= 1'b1;
      end
      if (prev_clr) begin
        prev_valid <= 1'b0;
      end
    end
  end

  assign busy = (state == ST_ARMED) || (state == ST_RUN);

endmodule
